gray_seg_display: RTL

Downstream display stage for the Gray counter system. It consumes the N-bit Gray code driven onto the LEDs, converts it to binary and then to BCD with a sequential double-dabble engine. It shows the decimal value on a 4-digit, common-anode, time-multiplexed 7-segment display. It sits beside the LED output and is driven from the counter's `gray_out` bus.

---
 rtl/gray_seg_display.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gray_seg_display.sv
// gray_seg_display: converts the Gray-coded counter value to binary, then to
// 3-digit BCD with a one-bit-per-cycle double-dabble engine, and drives a
// 4-digit common-anode multiplexed 7-segment display.
module gray_seg_display #(
  parameter int N       = 4,
  parameter int REFRESH = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] gray_in,
  output logic [3:0]   an,
  output logic [6:0]   seg,
  output logic         dp,
  output logic         busy
);

  localparam int SW = N + 12;
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [N-1:0]    gray_q, last_q, bin;
  logic [SW-1:0]   sr, sr_adj, sr_next;
  logic [3:0]      step;
  logic [11:0]     bcd_disp;
  logic [RW-1:0]   ref_cnt;
  logic [1:0]      digit;
  logic [3:0]      ones, tens, hund, nib;
  logic            blank;
  logic [6:0]      seg_d;
  logic [3:0]      an_d;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < N; i++) begin : g_bin
    assign bin[i] = ^(gray_q >> i);
  end

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    sr_adj = sr;
    for (int k = 0; k < 3; k++) begin
      if (sr_adj[N+4*k +: 4] >= 4'd5)
        sr_adj[N+4*k +: 4] = sr_adj[N+4*k +: 4] + 4'd3;
    end
    sr_next = sr_adj << 1;
  end

  // Input register: resample the Gray bus every cycle.
  always_ff @(posedge clk) begin
    if (rst) gray_q <= '0;
    else     gray_q <= gray_in;
  end

  // Conversion FSM: start on any input change, run N steps, latch the BCD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      last_q   <= '0;
      sr       <= '0;
      step     <= '0;
      bcd_disp <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gray_q != last_q) begin
            sr     <= {12'b0, bin};
            last_q <= gray_q;
            step   <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          sr   <= sr_next;
          step <= step + 4'd1;
          if (step == 4'(N-1)) begin
            bcd_disp <= sr_next[SW-1 -: 12];
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan timer: hold each digit for REFRESH cycles, then move to the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      digit   <= '0;
    end else if (ref_cnt == RW'(REFRESH-1)) begin
      ref_cnt <= '0;
      digit   <= digit + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  assign ones = bcd_disp[3:0];
  assign tens = bcd_disp[7:4];
  assign hund = bcd_disp[11:8];

  // Pick the nibble for the selected digit and suppress leading zeros.
  always_comb begin
    nib   = ones;
    blank = 1'b1;
    case (digit)
      2'd0: begin nib = ones; blank = 1'b0; end
      2'd1: begin nib = tens; blank = (tens == 4'd0) && (hund == 4'd0); end
      2'd2: begin nib = hund; blank = (hund == 4'd0); end
      default: begin nib = ones; blank = 1'b1; end
    endcase
  end

  // Active-low gfedcba segment decode.
  always_comb begin
    case (nib)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'h7F;
    endcase
    if (blank) seg_d = 7'h7F;
    an_d = ~(4'b0001 << digit);
  end

  // Registered display outputs; reset shows "0" on the rightmost digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

  assign dp = 1'b1;

endmodule
